// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: start bit, DATA_WIDTH data bits LSB first,
// optional even/odd parity, one or two stop bits, paced by an external BAUD_TICK.
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK_FSM,
  input  logic                  RST_FSM,
  input  logic                  BAUD_TICK,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  Data_Accept,
  output logic                  Frame_Done
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;
  logic                  par_en_q;
  logic                  stop2_q;
  logic                  par_bit;
  logic                  frame_end;

  assign frame_end = BAUD_TICK &&
                     ((state == S_STOP1 && !stop2_q) || state == S_STOP2);

  always_ff @(posedge CLK_FSM or negedge RST_FSM) begin
    if (!RST_FSM) begin
      state       <= S_IDLE;
      shreg       <= '0;
      cnt         <= '0;
      par_en_q    <= 1'b0;
      stop2_q     <= 1'b0;
      par_bit     <= 1'b0;
      TX_OUT      <= 1'b1;
      Busy        <= 1'b0;
      Data_Accept <= 1'b0;
      Frame_Done  <= 1'b0;
    end else begin
      Data_Accept <= 1'b0;
      Frame_Done  <= 1'b0;
      // Frame end takes priority so a waiting word chains straight into START.
      if (frame_end) begin
        Frame_Done <= 1'b1;
        if (Data_Valid) begin
          shreg       <= P_DATA;
          par_en_q    <= PAR_EN;
          stop2_q     <= STOP2;
          par_bit     <= ^P_DATA ^ PAR_TYP;
          Data_Accept <= 1'b1;
          cnt         <= '0;
          state       <= S_START;
          TX_OUT      <= 1'b0;
        end else begin
          state  <= S_IDLE;
          Busy   <= 1'b0;
          TX_OUT <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            TX_OUT <= 1'b1;
            if (Data_Valid) begin
              shreg       <= P_DATA;
              par_en_q    <= PAR_EN;
              stop2_q     <= STOP2;
              par_bit     <= ^P_DATA ^ PAR_TYP;
              Data_Accept <= 1'b1;
              Busy        <= 1'b1;
              state       <= S_ARM;
            end
          end
          S_ARM: begin
            if (BAUD_TICK) begin
              cnt    <= '0;
              state  <= S_START;
              TX_OUT <= 1'b0;
            end
          end
          S_START: begin
            if (BAUD_TICK) begin
              cnt    <= '0;
              state  <= S_DATA;
              TX_OUT <= shreg[0];
            end
          end
          S_DATA: begin
            if (BAUD_TICK) begin
              shreg <= shreg >> 1;
              cnt   <= cnt + CW'(1);
              if (cnt == LAST) begin
                state  <= par_en_q ? S_PARITY : S_STOP1;
                TX_OUT <= par_en_q ? par_bit : 1'b1;
              end else begin
                TX_OUT <= shreg[1];
              end
            end
          end
          S_PARITY: begin
            if (BAUD_TICK) begin
              state  <= S_STOP1;
              TX_OUT <= 1'b1;
            end
          end
          S_STOP1: begin
            if (BAUD_TICK) begin
              state  <= S_STOP2;
              TX_OUT <= 1'b1;
            end
          end
          S_STOP2: TX_OUT <= 1'b1;
          default: begin
            state  <= S_IDLE;
            Busy   <= 1'b0;
            TX_OUT <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_tx_frame_ctrl.md
# uart_tx_frame_ctrl

- Parametrised UART transmit frame controller: accepts a parallel word and serialises it on `TX_OUT`, LSB first.
- Frame: start bit, `DATA_WIDTH` data bits, optional even/odd parity bit, one or two stop bits.
- Bit timing comes from an external one-cycle `BAUD_TICK` strobe. The block has its own bit counter, shift register and parity generator, so it needs no separate serializer or parity unit.
- Sits between the TX data source and the line driver. It is the next generation of the TX control FSM: parametrised width, tick-aligned bit timing, parity type, stop-bit count and back-to-back framing.

## Interface
Parameters:
- `DATA_WIDTH`, default 8, data bits per frame; legal range 5..9.

Ports:
- `CLK_FSM` — in, 1, clock; all state changes on the rising edge.
- `RST_FSM` — in, 1, asynchronous, active-low reset.
- `BAUD_TICK` — in, 1, one-cycle strobe, one per bit period; at least 2 cycles apart.
- `P_DATA` — in, `DATA_WIDTH`, word to send; sampled only on acceptance.
- `Data_Valid` — in, 1, request to send `P_DATA`.
- `PAR_EN` — in, 1, parity bit enable; sampled on acceptance.
- `PAR_TYP` — in, 1, 0 = even parity, 1 = odd parity; sampled on acceptance.
- `STOP2` — in, 1, 1 = two stop bits; sampled on acceptance.
- `TX_OUT` — out, 1, serial line, registered; idle high.
- `Busy` — out, 1, registered; 1 from the cycle after acceptance until the frame ends.
- `Data_Accept` — out, 1, registered one-cycle pulse the cycle after a word is latched.
- `Frame_Done` — out, 1, registered one-cycle pulse after the last stop bit completes.

## Operation
- States: `IDLE`, `ARM`, `START`, `DATA`, `PARITY`, `STOP1`, `STOP2`.
- **Acceptance:** occurs at a rising edge where the state is `IDLE` and `Data_Valid` = 1, or in the back-to-back case below.
  - Latches `P_DATA` into the shift register, and `PAR_EN`, `PAR_TYP`, `STOP2` into config registers.
  - Latches the parity bit: XOR of `P_DATA`, inverted when `PAR_TYP` = 1.
  - Input changes after acceptance do not affect the frame in flight.
- **`IDLE`:** `TX_OUT` = 1, `Busy` = 0. On acceptance go to `ARM`.
- **`ARM`:** `TX_OUT` = 1, `Busy` = 1. Waits for the first `BAUD_TICK`, so every bit lasts exactly one tick period. On a tick go to `START`.
- **`START`:** `TX_OUT` = 0. On a tick go to `DATA` with bit count 0.
- **`DATA`:** `TX_OUT` = shift register bit 0.
  - On each tick: shift right and increment the count.
  - On the tick with count = `DATA_WIDTH`-1: go to `PARITY` if the latched `PAR_EN` = 1, else `STOP1`.
- **`PARITY`:** `TX_OUT` = latched parity bit. On a tick go to `STOP1`.
- **`STOP1`:** `TX_OUT` = 1. On a tick go to `STOP2` if the latched `STOP2` = 1; otherwise the frame ends.
- **`STOP2`:** `TX_OUT` = 1. On a tick the frame ends.
- **Frame end:**
  - If `Data_Valid` = 1 on the same edge: accept the new word and go directly to `START`. No idle bit, no `ARM`, `Busy` stays 1.
  - Otherwise go to `IDLE`, `Busy` = 0.
  - `Frame_Done` pulses in either case.
- **`Data_Valid` while busy:** ignored except at the frame-end edge; `Data_Accept` stays 0. The source holds `Data_Valid` until it sees `Data_Accept`.
- **Bit counter:** width `$clog2(DATA_WIDTH)`, cleared on entry to `START`.
- **Reset:** asynchronous, effective mid-frame. Outputs immediately return to `TX_OUT` = 1, `Busy` = 0, `Data_Accept` = 0, `Frame_Done` = 0; state `IDLE`; counter and shift register cleared.

## Timing
- **Acceptance:** `Data_Accept` and `Busy` rise 1 cycle after the acceptance edge.
- **Start bit:** `TX_OUT` falls 1 cycle after the first tick edge following acceptance. A tick coincident with the acceptance edge is not used.
- **Bit boundaries:** each bit occupies the cycles between consecutive tick edges.
- **Frame length:** 1 + `DATA_WIDTH` + `PAR_EN` + (1 + `STOP2`) tick periods, plus the `ARM` wait.
- **Frame end:** `Frame_Done` is high the cycle after the last stop tick edge. `Busy` falls the same cycle, unless there is a back-to-back acceptance.
- `BAUD_TICK` has no effect in `IDLE`.

## Test plan
- **Basic 8N1:** `DATA_WIDTH` 8, `P_DATA` 0xA5, `PAR_EN` 0, `STOP2` 0, tick every 16 cycles.
  - `TX_OUT` sequence 0,1,0,1,0,0,1,0,1,1.
  - `Busy` high for `ARM` + 10 bit periods; one `Frame_Done` pulse.
- **Parity:** `P_DATA` 0x07, even parity → parity bit 1; odd parity → 0. With `STOP2` = 1, two high stop bits before `Busy` falls.
- **Back-to-back:** `Data_Valid` held high across two words, 0x01 then 0xFF.
  - Second start bit immediately follows the first frame's stop bit.
  - `Busy` never drops; two `Data_Accept` pulses.
- **`DATA_WIDTH` = 5:** `P_DATA` 0x1B, odd parity → `TX_OUT` sequence 0,1,1,0,1,1,1,1 (start, 5 data, parity 1, stop); counter wraps correctly.
- **Reset mid-frame:** assert `RST_FSM` during `DATA` bit 3.
  - `TX_OUT` = 1 and `Busy` = 0 immediately.
  - After release, a new word transmits with a full start bit.
- **Ignored request:** pulse `Data_Valid` during `PARITY` → no `Data_Accept`; frame contents unchanged.
